multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL provide parameter WAIT_LIMIT, default 15, maximum cycles spent waiting on mem_ready before a bus error.
REQ-003 Port: clock, input, 1, single rising-edge clock.
REQ-004 Port: reset, input, 1, asynchronous, active-high reset.
REQ-005 Port: enable, input, 1, advance permission; 0 freezes the FSM.
REQ-006 Port: opcode, input, 6, instruction-register bits [31:26].
REQ-007 Port: mem_ready, input, 1, memory completes the current access this cycle.
REQ-008 Port: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, output, 1 each, standard multicycle datapath controls.
REQ-009 Port: ALUSrcB, ALUOp, PCSource, output, 2 each, datapath mux and ALU-class selects.
REQ-010 Port: state, output, 4, current FSM state code.
REQ-011 Port: retired, output, CNT_W, count of completed instructions.
REQ-012 Port: illegal, output, 1, sticky flag for an unsupported opcode.
REQ-013 Port: bus_error, output, 1, sticky flag for a mem_ready timeout.

Function
REQ-014 State codes SHALL be:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERR=12
REQ-015 Supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000 and j 000010.
REQ-016 Transitions SHALL be:
- FETCH->DECODE
- DECODE->MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j), ERR (other opcodes)
- MEMADR->MEMRD (lw) or MEMWR (sw)
- MEMRD->MEMWB; EXEC->RWB; ADDIEX->ADDIWB
- MEMWB, MEMWR, RWB, ADDIWB, BRANCH, JUMP->FETCH
REQ-017 FETCH, MEMRD and MEMWR SHALL hold until mem_ready=1 and leave on the edge where mem_ready=1.
REQ-018 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; IRWrite and PCWrite SHALL be 1 only in the cycle in which mem_ready=1.
REQ-019 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00.
REQ-020 MEMADR and ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00.
REQ-021 MEMRD SHALL drive MemRead=1 and IorD=1.
REQ-022 MEMWR SHALL drive IorD=1, with MemWrite=1 only in the cycle in which mem_ready=1.
REQ-023 MEMWB SHALL drive RegWrite=1, MemToReg=1 and RegDst=0.
REQ-024 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10.
REQ-025 RWB SHALL drive RegWrite=1, RegDst=1 and MemToReg=0.
REQ-026 ADDIWB SHALL drive RegWrite=1, RegDst=0 and MemToReg=0.
REQ-027 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01.
REQ-028 JUMP SHALL drive PCWrite=1 and PCSource=10.
REQ-029 Every output not listed for a state SHALL be 0 in that state.
REQ-030 When enable=0, the state SHALL hold; PCWrite, PCWriteCond, IRWrite, MemWrite and RegWrite SHALL be 0; the select outputs SHALL keep their state-decoded values.
REQ-031 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on each transition from MEMWB, MEMWR, RWB, ADDIWB, BRANCH or JUMP to FETCH.
REQ-032 A wait counter SHALL clear on entering FETCH, MEMRD or MEMWR and increment each enabled cycle in which mem_ready=0.
REQ-033 When the wait counter reaches WAIT_LIMIT, the FSM SHALL go to ERR with bus_error=1, and SHALL NOT increment retired.
REQ-034 Entering ERR from DECODE SHALL set illegal=1.
REQ-035 ERR SHALL be absorbing: all strobes 0 and no exit except reset.
REQ-036 When mem_ready=1 arrives on the same edge the wait counter would reach WAIT_LIMIT, mem_ready SHALL win and the access SHALL complete normally.

Reset
REQ-037 While reset=1, asynchronously: state=FETCH, retired=0, illegal=0, bus_error=0, wait counter=0.
REQ-038 Reset asserted mid-instruction SHALL abort that instruction, with no increment of retired.
REQ-039 During reset, all outputs SHALL equal the FETCH decode with IRWrite=0 and PCWrite=0.

Verification
REQ-040 Scenario: reset, enable=1, mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; retired=1.
REQ-041 Scenario: opcode=101011 with mem_ready held 0 for 3 cycles in MEMWR -> MemWrite pulses once in the cycle mem_ready=1; retired increments by 1.
REQ-042 Scenario: sequence R-type, beq, addi, j with mem_ready=1 -> per-instruction lengths 4,3,4,3 cycles; retired=4.
REQ-043 Scenario: opcode=111111 -> ERR after DECODE; illegal=1; all strobes 0 for 20 further cycles; reset clears the flag.
REQ-044 Scenario: mem_ready=0 in FETCH with WAIT_LIMIT=15 -> ERR after 15 cycles; bus_error=1; retired unchanged.
REQ-045 Scenario: enable dropped for 5 cycles in EXEC, then reset pulsed in MEMRD -> state frozen at 6 during the 5 cycles; state=0 and retired=0 immediately on reset.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state-decoded datapath controls,
// memory wait timeout, retired-instruction counter and sticky error flags.
module multicycle_control #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_error
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERR    = 4'd12
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic               bus_error_q, bus_error_d;

    logic               in_wait_state;
    logic [WAIT_W-1:0]  wait_inc;
    logic               wait_hit;

    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wait_inc      = wait_q + WAIT_W'(1);
    assign wait_hit      = (wait_inc == WAIT_W'(WAIT_LIMIT));

    // State, wait counter, retired counter and sticky flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next state and bookkeeping; mem_ready beats a coincident timeout
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;

        if (enable) begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem_ready)     state_d = S_DECODE;
                    else if (wait_hit) state_d = S_ERR;
                end
                S_DECODE: begin
                    unique case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_ERR;
                    endcase
                end
                S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (mem_ready)     state_d = S_MEMWB;
                    else if (wait_hit) state_d = S_ERR;
                end
                S_MEMWR: begin
                    if (mem_ready)     state_d = S_FETCH;
                    else if (wait_hit) state_d = S_ERR;
                end
                S_EXEC:   state_d = S_RWB;
                S_ADDIEX: state_d = S_ADDIWB;
                S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
                S_ERR:    state_d = S_ERR;
                default:  state_d = S_ERR;
            endcase
        end

        if (state_d != state_q) begin
            if ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR))
                wait_d = '0;
            if (state_d == S_FETCH)
                retired_d = retired_q + CNT_W'(1);
            if (state_d == S_ERR) begin
                if (state_q == S_DECODE) illegal_d   = 1'b1;
                else                     bus_error_d = 1'b1;
            end
        end else if (enable && in_wait_state && !mem_ready) begin
            wait_d = wait_inc;
        end
    end

    // Datapath control decode; write strobes masked while frozen or in reset
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;

        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase

        if (!enable || reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state     = state_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;

endmodule
